// File: rtl/dmem_bank_pkg.sv
// Shared types and defaults for the MIPS-E data memory bank.
// The clear/run state encodings live here so the bench and RTL agree on them.
package dmem_bank_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 4096;

    // Index width for a storage array of the given depth (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Storage for dmem_bank: one byte-masked write port and one read port,
// combinational (RD_LAT=0) or registered read-first (RD_LAT=1, block-RAM friendly).
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 12,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic                rd_valid,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array: contents survive reset and are only zeroed by CLEAR.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_comb_rd
            logic unused_rd_lat0;
            assign unused_rd_lat0 = rst_n & rd_en;
            assign rd_data = rd_valid ? mem[rd_addr] : '0;
        end else begin : g_reg_rd
            logic [DATA_W-1:0] rd_q;
            // Non-blocking sampling gives read-first behaviour on a same-address write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= rd_valid ? mem[rd_addr] : '0;
                end
            end
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_bank.sv
// MIPS-E data memory bank: clear-after-reset sequencer, CPU port with byte enables,
// loader port, and sticky out-of-range write flag.
module dmem_bank
    import dmem_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = 0,
    parameter int CLR_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   a,
    output logic [DATA_W-1:0]   rd,
    input  logic [DATA_W-1:0]   wd,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                oor,
    output state_t              dbg_state
);

    localparam int                IDX_W   = idx_width(DEPTH);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    state_t             state;
    logic [IDX_W-1:0]   clr_cnt;
    logic               a_in, ld_in, cpu_wr, oor_set;
    logic               arr_we;
    logic [IDX_W-1:0]   arr_addr;
    logic [DATA_W-1:0]  arr_data;
    logic [DATA_W/8-1:0] arr_be;

    assign dbg_state = state;

    // Extra leading zero lets DEPTH == 2**ADDR_W compare correctly.
    assign a_in  = ({1'b0, a} < DEPTH_X);
    assign ld_in = ({1'b0, ld_addr} < DEPTH_X);

    // Loader handshake: a transfer occurs on any posedge where ld_valid && ld_ready;
    // ld_ready is combinational and drops whenever the CPU writes, so the loader
    // must hold ld_valid/ld_addr/ld_data stable until it sees ld_ready high.
    assign cpu_wr   = ready & rst_n & we & (|be);
    assign ld_ready = ready & rst_n & ld_valid & ~we;
    assign oor_set  = (cpu_wr & ~a_in) | (ld_ready & ~ld_in);

    always_comb begin
        arr_we   = 1'b0;
        arr_addr = clr_cnt;
        arr_data = '0;
        arr_be   = '1;
        if (state == ST_CLEAR) begin
            arr_we = rst_n;
        end else if (cpu_wr) begin
            arr_we   = a_in;
            arr_addr = a[IDX_W-1:0];
            arr_data = wd;
            arr_be   = be;
        end else if (ld_ready) begin
            arr_we   = ld_in;
            arr_addr = ld_addr[IDX_W-1:0];
            arr_data = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLR_EN != 0) ? ST_CLEAR : ST_RUN;
            ready   <= (CLR_EN == 0);
            clr_cnt <= '0;
            oor     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (oor_set) oor <= 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (arr_we),
        .wr_addr  (arr_addr),
        .wr_data  (arr_data),
        .wr_be    (arr_be),
        .rd_en    (ready),
        .rd_valid (a_in),
        .rd_addr  (a[IDX_W-1:0]),
        .rd_data  (rd)
    );

endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank: one combinational-read and one registered-read
// instance (DEPTH=16) share the same stimulus.
module tb_dmem_bank;
    import dmem_bank_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          we;
    logic [3:0]    be;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic [DW-1:0] rd0, rd1;
    logic          ready0, ready1, ldr0, ldr1, oor0, oor1;
    state_t        st0, st1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(0), .CLR_EN(1)) u0 (
        .clk(clk), .rst_n(rst_n), .a(a), .rd(rd0), .wd(wd), .we(we), .be(be),
        .ready(ready0), .ld_valid(ld_valid), .ld_ready(ldr0), .ld_addr(ld_addr),
        .ld_data(ld_data), .oor(oor0), .dbg_state(st0)
    );

    dmem_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(1), .CLR_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a), .rd(rd1), .wd(wd), .we(we), .be(be),
        .ready(ready1), .ld_valid(ld_valid), .ld_ready(ldr1), .ld_addr(ld_addr),
        .ld_data(ld_data), .oor(oor1), .dbg_state(st1)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [3:0]    be;
        logic          ld_v;
        logic [AW-1:0] ld_a;
        logic [DW-1:0] ld_d;
        logic          exp_ldr;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; be = '0; wd = '0; a = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    endtask

    // Counts posedges until ready rises; bounded so a stuck DUT still reaches the summary.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready0 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'd16);
        chk({name, "_lat1"}, 32'(ready1), 32'd1);
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < DEP; i++) begin
            a = AW'(i);
            #1;
            chk($sformatf("%s[%0d]", name, i), rd0, 32'h0);
        end
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 16'd2,  32'h070c0001, 4'b1111, 1'b0, 16'd0,  32'h0,        1'b0, 16'd2,  32'h070c0001};
        vecs[1] = '{1'b1, 16'd2,  32'hAABBCCDD, 4'b0101, 1'b0, 16'd0,  32'h0,        1'b0, 16'd2,  32'h07BB00DD};
        vecs[2] = '{1'b1, 16'd2,  32'hFFFFFFFF, 4'b0000, 1'b1, 16'd9,  32'h99999999, 1'b0, 16'd2,  32'h07BB00DD};
        vecs[3] = '{1'b1, 16'd6,  32'h11223344, 4'b1010, 1'b0, 16'd0,  32'h0,        1'b0, 16'd6,  32'h11003300};
        vecs[4] = '{1'b0, 16'd0,  32'h0,        4'b0000, 1'b1, 16'd7,  32'hDEADBEEF, 1'b1, 16'd7,  32'hDEADBEEF};
        vecs[5] = '{1'b0, 16'd0,  32'h0,        4'b0000, 1'b1, 16'd0,  32'hCAFEF00D, 1'b1, 16'd0,  32'hCAFEF00D};
        vecs[6] = '{1'b1, 16'd15, 32'hA5A5A5A5, 4'b1111, 1'b0, 16'd0,  32'h0,        1'b0, 16'd15, 32'hA5A5A5A5};
        vecs[7] = '{1'b0, 16'd0,  32'h0,        4'b0000, 1'b1, 16'd15, 32'h00000001, 1'b1, 16'd15, 32'h00000001};
        vecs[8] = '{1'b1, 16'd0,  32'h5A000000, 4'b1000, 1'b0, 16'd0,  32'h0,        1'b0, 16'd0,  32'h5AFEF00D};

        // Reset state
        idle_inputs();
        ld_valid = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_ready_lat1", 32'(ready1), 32'd0);
        chk("rst_ld_ready", 32'(ldr0), 32'd0);
        chk("rst_oor", 32'(oor0), 32'd0);
        chk("rst_rd_reg", rd1, 32'h0);
        chk("rst_state", 32'(st0), 32'(ST_CLEAR));
        ld_valid = 1'b0;

        // Clear sequence after release
        rst_n = 1'b1;
        wait_ready("clr_ready_cycles");
        chk("clr_state_run", 32'(st0), 32'(ST_RUN));
        read_all_zero("clr_rd");

        // Table-driven writes, byte enables and loader transfers
        for (int k = 0; k < 9; k++) begin
            we = vecs[k].we; a = vecs[k].a; wd = vecs[k].wd; be = vecs[k].be;
            ld_valid = vecs[k].ld_v; ld_addr = vecs[k].ld_a; ld_data = vecs[k].ld_d;
            #1;
            chk($sformatf("vec%0d_ld_ready", k), 32'(ldr0), 32'(vecs[k].exp_ldr));
            tick();
            idle_inputs();
            a = vecs[k].ra;
            #1;
            chk($sformatf("vec%0d_rd", k), rd0, vecs[k].exp_rd);
            chk($sformatf("vec%0d_oor", k), 32'(oor0), 32'd0);
        end

        // Arbitration: CPU write wins, loader held until accepted
        ld_valid = 1'b1; ld_addr = 16'd3; ld_data = 32'h12345678;
        we = 1'b1; a = 16'd4; wd = 32'h1; be = 4'b1111;
        #1;
        chk("arb_ld_blocked", 32'(ldr0), 32'd0);
        tick();
        we = 1'b0;
        #1;
        chk("arb_ld_accept", 32'(ldr0), 32'd1);
        tick();
        idle_inputs();
        a = 16'd3;
        #1;
        chk("arb_mem3", rd0, 32'h12345678);
        a = 16'd4;
        #1;
        chk("arb_mem4", rd0, 32'h1);

        // Registered read is read-first
        we = 1'b1; a = 16'd5; wd = 32'h5; be = 4'b1111;
        tick();
        we = 1'b0;
        tick();
        chk("rl1_pre", rd1, 32'h5);
        we = 1'b1; wd = 32'h9;
        tick();
        chk("rl1_read_first", rd1, 32'h5);
        chk("rl0_after_edge", rd0, 32'h9);
        we = 1'b0;
        tick();
        chk("rl1_new", rd1, 32'h9);

        // Out-of-range write and read
        a = 16'd20;
        #1;
        chk("oor_rd_comb", rd0, 32'h0);
        tick();
        chk("oor_rd_reg", rd1, 32'h0);
        we = 1'b1; wd = 32'hFFFFFFFF; be = 4'b1111;
        tick();
        we = 1'b0;
        chk("oor_set", 32'(oor0), 32'd1);
        chk("oor_set_lat1", 32'(oor1), 32'd1);
        a = 16'd4;
        #1;
        chk("oor_no_alias", rd0, 32'h1);
        repeat (5) tick();
        chk("oor_sticky", 32'(oor0), 32'd1);

        // Reset mid-CLEAR restarts from address 0
        rst_n = 1'b0;
        #2;
        chk("rst2_oor", 32'(oor0), 32'd0);
        chk("rst2_ready", 32'(ready0), 32'd0);
        chk("rst2_rd_reg", rd1, 32'h0);
        rst_n = 1'b1;
        repeat (7) tick();
        chk("mid_clr_state", 32'(st0), 32'(ST_CLEAR));
        chk("mid_clr_ready", 32'(ready0), 32'd0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        we = 1'b1; a = 16'd2; wd = 32'hFFFFFFFF; be = 4'b1111;
        ld_valid = 1'b1; ld_addr = 16'd8; ld_data = 32'h88888888;
        #1;
        chk("clr_ld_ignored", 32'(ldr0), 32'd0);
        wait_ready("reclr_ready_cycles");
        idle_inputs();
        read_all_zero("reclr_rd");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
